// File: rtl/fpnew_pkg.sv
// fpnew_pkg: shared fpnew types used by the result buffer.
package fpnew_pkg;
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;
endpackage

// File: rtl/fpnew_result_fifo_mem.sv
// fpnew_result_fifo_mem: Depth-entry register array, one write port, one async read port.
module fpnew_result_fifo_mem
  import fpnew_pkg::*;
#(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4,
  parameter type TagType = logic,
  localparam int unsigned PtrWidth = $clog2(Depth)
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [PtrWidth-1:0] waddr_i,
  input  logic [Width-1:0]    result_i,
  input  status_t             status_i,
  input  TagType              tag_i,
  input  logic [PtrWidth-1:0] raddr_i,
  output logic [Width-1:0]    result_o,
  output status_t             status_o,
  output TagType              tag_o
);
  logic [Width-1:0] result_q [Depth];
  status_t          status_q [Depth];
  TagType           tag_q    [Depth];
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      result_q[waddr_i] <= result_i;
      status_q[waddr_i] <= status_i;
      tag_q[waddr_i]    <= tag_i;
    end
  end
  assign result_o = result_q[raddr_i];
  assign status_o = status_q[raddr_i];
  assign tag_o    = tag_q[raddr_i];
endmodule

// File: rtl/fpnew_result_buffer.sv
// fpnew_result_buffer: elastic result FIFO at the pipeline output with sticky flag accumulation.
module fpnew_result_buffer
  import fpnew_pkg::*;
#(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4,
  parameter type TagType = logic,
  localparam int unsigned PtrWidth = $clog2(Depth),
  localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [Width-1:0]    result_i,
  input  status_t             status_i,
  input  TagType              tag_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [Width-1:0]    result_o,
  output status_t             status_o,
  output TagType              tag_o,
  input  logic                flush_i,
  input  logic                clr_flags_i,
  output status_t             acc_flags_o,
  output logic [CntWidth-1:0] fill_o,
  output logic                busy_o
);
  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $error("fpnew_result_buffer: Depth must be a power of 2 and >= 2");
  end
  logic [PtrWidth-1:0] wr_ptr, rd_ptr;
  logic [CntWidth-1:0] count;
  status_t             acc_q;
  logic                push, pop, pop_ok;
  assign in_ready_o  = count != CntWidth'(Depth);
  assign out_valid_o = count != '0;
  assign busy_o      = out_valid_o;
  assign fill_o      = count;
  assign acc_flags_o = acc_q;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  // a pop coinciding with flush is discarded, so it must not feed the flags
  assign pop_ok      = pop & ~flush_i;
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PtrWidth'(push);
      rd_ptr <= rd_ptr + PtrWidth'(pop);
      count  <= count + CntWidth'(push) - CntWidth'(pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) acc_q <= '0;
    else if (clr_flags_i) acc_q <= pop_ok ? status_o : '0;
    else if (pop_ok) acc_q <= status_t'(acc_q | status_o);
  end
  fpnew_result_fifo_mem #(
    .Width  (Width),
    .Depth  (Depth),
    .TagType(TagType)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (push & ~flush_i & ~rst_i),
    .waddr_i (wr_ptr),
    .result_i(result_i),
    .status_i(status_i),
    .tag_i   (tag_i),
    .raddr_i (rd_ptr),
    .result_o(result_o),
    .status_o(status_o),
    .tag_o   (tag_o)
  );
endmodule

// File: doc/fpnew_result_buffer.md
# fpnew_result_buffer

Elastic result collector at the consumer end of an fpnew operation pipeline. It drives the pipeline's `out_ready_i` and absorbs its `out_valid_o` / result / status / tag stream into a small circular FIFO, so downstream stalls never propagate combinationally into the pipeline. It also accumulates the sticky exception flags of delivered results, fflags-style, for the core's CSR logic.

## Interface
Parameters:
- `Width`, default 32: result word width in bits.
- `Depth`, default 4: FIFO entries; must be a power of 2 and ≥ 2.
- `TagType`, default `logic`: opaque tag travelling with each result.
- `PtrWidth`, localparam: `$clog2(Depth)`.

Ports:
- `clk_i`, input, 1: clock; all state updates on the rising edge.
- `rst_i`, input, 1: reset, synchronous and active-high.
- `in_valid_i`, input, 1: pipeline result valid.
- `in_ready_o`, output, 1: buffer can accept; connects to the pipeline's `out_ready_i`.
- `result_i`, input, Width: result data.
- `status_i`, input, `fpnew_pkg::status_t`: exception flags of the result.
- `tag_i`, input, `TagType`: result tag.
- `out_valid_o`, output, 1: head entry valid.
- `out_ready_i`, input, 1: downstream accepts the head entry.
- `result_o`, output, Width: head result.
- `status_o`, output, `fpnew_pkg::status_t`: head flags.
- `tag_o`, output, `TagType`: head tag.
- `flush_i`, input, 1: synchronous discard of all buffered entries.
- `clr_flags_i`, input, 1: clear the accumulated flags.
- `acc_flags_o`, output, `fpnew_pkg::status_t`: OR of `status` of every popped entry since the last clear.
- `fill_o`, output, `$clog2(Depth+1)`: current occupancy.
- `busy_o`, output, 1: buffer non-empty.

## Operation
- Push: `in_valid_i & in_ready_o`. The entry is written at `wr_ptr` and `wr_ptr` increments modulo Depth.
- Pop: `out_valid_o & out_ready_i`. `rd_ptr` increments modulo Depth.
- `count` is updated as +1 (push only), −1 (pop only), or unchanged (both or neither).
- `in_ready_o = (count != Depth)`. It is a function of registered state only; there is no path from `out_ready_i`.
  - Consequence: when full, a simultaneous pop does not enable a push in the same cycle.
- `out_valid_o = (count != 0)`.
- Head outputs `result_o` / `status_o` / `tag_o` are read from `mem[rd_ptr]`. They hold stable while `out_valid_o & ~out_ready_i`.
- Pointer wrap-around: pointers are PtrWidth bits wide and wrap naturally; full versus empty is distinguished by `count` only.
- Flag accumulation: on a pop, `acc_flags <= acc_flags | status_o`.
  - `clr_flags_i` has priority: the register is loaded with the popped status if a pop happens in the same cycle, otherwise with `'0`.
- `flush_i`: the next state is `count = 0` and `wr_ptr = rd_ptr = 0`.
  - A push or pop in the flush cycle is discarded.
  - A pop in the flush cycle does not update `acc_flags`.
  - `flush_i` does not clear `acc_flags`.
- Reset (`rst_i` high at a clock edge, including mid-stream): pointers, `count` and `acc_flags` go to 0. Memory contents are not reset.
- Output values under reset: `in_ready_o = 1`, `out_valid_o = 0`, `acc_flags_o = 0`, `fill_o = 0`, `busy_o = 0`.
- `busy_o = (count != 0)`.
- `fill_o = count`.

## Timing
- Latency: an entry pushed in cycle N is visible on `out_valid_o` in cycle N+1 (no fall-through).
- Throughput: 1 entry/cycle sustained while 0 < count < Depth.
- `acc_flags_o` reflects a pop in cycle N from cycle N+1.
- Combinational paths into outputs:
  - Only the head data mux (`rd_ptr` → `mem`) reaches outputs.
  - No input-to-output combinational path exists for the handshake signals.
- Priority per cycle: `rst_i` > `flush_i` > push/pop.

## Structure
- `fpnew_pkg::status_t` stays in the shared package. No new package types are needed.
- Storage: a natural sub-module `fpnew_result_fifo_mem`, a register array of Depth × {Width, status_t, TagType} with one write port and one async read port. Control (pointers, count, flags) lives in the top.
- An elaboration-time assertion rejects Depth that is not a power of 2 or is less than 2.

## Test plan
- Fill and drain, Depth=4, `out_ready_i=0`:
  - Push results 0x1..0x4: `in_ready_o` falls after the 4th push, `fill_o=4`.
  - Raise `out_ready_i`: results 0x1, 0x2, 0x3, 0x4 are emitted in order, then `busy_o=0`.
- Streaming: `in_valid_i` and `out_ready_i` held high for 20 cycles.
  - `fill_o` stays at 1 and one result is delivered every cycle, with tags matching input order.
  - Pointers wrap at least 4 times.
- Full with simultaneous pop: at `count=4`, assert `in_valid_i` and `out_ready_i`.
  - No push that cycle: `in_ready_o=0`, `fill_o` goes to 3.
  - A push is accepted in the next cycle.
- Flags:
  - Pop entries with status NX (0x01) then OF (0x04): `acc_flags_o=0x05`.
  - Pulse `clr_flags_i` while popping status UF (0x02): `acc_flags_o=0x02`.
- Flush mid-stream with `fill_o=3` and a push and pop in the same cycle:
  - Next cycle: `fill_o=0`, `out_valid_o=0`, `acc_flags_o` unchanged.
  - Subsequent pushes start at entry 0.
- Reset mid-operation: assert `rst_i` with `fill_o=2` and `acc_flags_o=0x10`.
  - Next cycle: all outputs at their reset values.
  - The first post-reset push appears after 1 cycle.
